// File: rtl/prgrm_cnt_stk.sv
// Fetch-stage program counter with a return-address LIFO; single-cycle update, stall freezes all state.
// No valid/ready handshake: strobes are one-hot by contract and resolved by fixed priority.
`timescale 1ns/1ps

module prgrm_cnt_stk #(
  parameter  int ADDR_W    = 8,
  parameter  int STK_DEPTH = 8,
  localparam int DEPTH_W   = $clog2(STK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               incrmnt_pc,
  input  logic               ld_brnch_addr,
  input  logic               ld_rel_addr,
  input  logic               call,
  input  logic               rtn,
  input  logic               clr_err,
  input  logic [ADDR_W-1:0]  imm_addr,
  input  logic [ADDR_W-1:0]  rel_offset,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  tos,
  output logic [DEPTH_W-1:0] stk_depth,
  output logic               stk_empty,
  output logic               stk_full,
  output logic               stk_ovf,
  output logic               stk_unf
);

  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [ADDR_W-1:0]  stk_mem [STK_DEPTH];
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic [DEPTH_W-1:0] depth_m1;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   top_idx;
  logic               ovf_nxt;
  logic               unf_nxt;
  logic               push;

  assign pc_inc    = pc + ADDR_W'(1);
  assign depth_m1  = stk_depth - DEPTH_W'(1);
  assign top_idx   = depth_m1[IDX_W-1:0];
  assign push_idx  = stk_depth[IDX_W-1:0];
  assign stk_empty = (stk_depth == '0);
  assign stk_full  = (stk_depth == DEPTH_W'(STK_DEPTH));
  assign tos       = stk_empty ? '0 : stk_mem[top_idx];

  // Error flags clear first so a same-cycle overflow/underflow event overrides clr_err.
  always_comb begin
    pc_nxt    = pc;
    depth_nxt = stk_depth;
    ovf_nxt   = stk_ovf;
    unf_nxt   = stk_unf;
    push      = 1'b0;
    if (!stall) begin
      if (clr_err) begin
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
      end
      if (rtn) begin
        if (stk_empty) begin
          unf_nxt = 1'b1;
        end else begin
          pc_nxt    = stk_mem[top_idx];
          depth_nxt = depth_m1;
        end
      end else if (call) begin
        if (stk_full) begin
          ovf_nxt = 1'b1;
        end else begin
          push      = 1'b1;
          pc_nxt    = imm_addr;
          depth_nxt = stk_depth + DEPTH_W'(1);
        end
      end else if (ld_brnch_addr) begin
        pc_nxt = imm_addr;
      end else if (ld_rel_addr) begin
        pc_nxt = pc + rel_offset;
      end else if (incrmnt_pc) begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      stk_depth <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      for (int i = 0; i < STK_DEPTH; i++) stk_mem[i] <= '0;
    end else begin
      pc        <= pc_nxt;
      stk_depth <= depth_nxt;
      stk_ovf   <= ovf_nxt;
      stk_unf   <= unf_nxt;
      if (push) stk_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_prgrm_cnt_stk.sv
// Bench for prgrm_cnt_stk: directed scenarios plus randomized strobes against a queue-based model.
`timescale 1ns/1ps

module tb_prgrm_cnt_stk;

  localparam int AW = 8;
  localparam int SD = 8;
  localparam int DW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0, incrmnt_pc = 1'b0, ld_brnch_addr = 1'b0, ld_rel_addr = 1'b0;
  logic          call = 1'b0, rtn = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] imm_addr = '0, rel_offset = '0;
  logic [AW-1:0] pc, tos;
  logic [DW-1:0] stk_depth;
  logic          stk_empty, stk_full, stk_ovf, stk_unf;

  int tests_run = 0;
  int tests_failed = 0;

  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  logic          m_ovf, m_unf;

  prgrm_cnt_stk #(.ADDR_W(AW), .STK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .stall(stall), .incrmnt_pc(incrmnt_pc),
    .ld_brnch_addr(ld_brnch_addr), .ld_rel_addr(ld_rel_addr), .call(call), .rtn(rtn),
    .clr_err(clr_err), .imm_addr(imm_addr), .rel_offset(rel_offset), .pc(pc), .tos(tos),
    .stk_depth(stk_depth), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pc = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  function automatic logic [AW-1:0] m_tos();
    return (m_stk.size() == 0) ? '0 : m_stk[$];
  endfunction

  // One fetch-cycle of architectural behaviour, from the currently applied strobes.
  task automatic model_step();
    if (stall) return;
    if (clr_err) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (rtn) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (call) begin
      if (m_stk.size() == SD) m_ovf = 1'b1;
      else begin
        m_stk.push_back(AW'(m_pc + 1));
        m_pc = imm_addr;
      end
    end else if (ld_brnch_addr) m_pc = imm_addr;
    else if (ld_rel_addr) m_pc = AW'(m_pc + rel_offset);
    else if (incrmnt_pc) m_pc = AW'(m_pc + 1);
  endtask

  task automatic drive(input logic s, input logic inc, input logic br, input logic rl,
                       input logic cl, input logic rt, input logic ce,
                       input logic [AW-1:0] imm, input logic [AW-1:0] off);
    stall = s; incrmnt_pc = inc; ld_brnch_addr = br; ld_rel_addr = rl;
    call = cl; rtn = rt; clr_err = ce; imm_addr = imm; rel_offset = off;
    @(posedge clk);
    model_step();
    #1;
    stall = 0; incrmnt_pc = 0; ld_brnch_addr = 0; ld_rel_addr = 0;
    call = 0; rtn = 0; clr_err = 0;
  endtask

  task automatic do_inc();                     drive(0,1,0,0,0,0,0,'0,'0); endtask
  task automatic do_br(input logic [AW-1:0] a);  drive(0,0,1,0,0,0,0,a,'0);  endtask
  task automatic do_rel(input logic [AW-1:0] o); drive(0,0,0,1,0,0,0,'0,o);  endtask
  task automatic do_call(input logic [AW-1:0] a); drive(0,0,0,0,1,0,0,a,'0); endtask
  task automatic do_rtn();                     drive(0,0,0,0,0,1,0,'0,'0); endtask
  task automatic do_clr();                     drive(0,0,0,0,0,0,1,'0,'0); endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #12;
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h want 00", pc); end
    tests_run++; if (stk_depth !== 4'd0) begin tests_failed++; $display("FAIL reset_depth: got %0d want 0", stk_depth); end
    tests_run++; if (tos !== 8'h00) begin tests_failed++; $display("FAIL reset_tos: got %h want 00", tos); end
    tests_run++; if ({stk_empty, stk_full, stk_ovf, stk_unf} !== 4'b1000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 1000", {stk_empty, stk_full, stk_ovf, stk_unf}); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL idle_hold: got %h want 00", pc); end
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 257; i++) begin
      do_inc();
      tests_run++;
      if (pc !== AW'(i) || {stk_ovf, stk_unf, stk_empty} !== 3'b001) begin
        tests_failed++;
        $display("FAIL increment_%0d: got pc=%h flags=%b want pc=%h flags=001", i, pc,
                 {stk_ovf, stk_unf, stk_empty}, AW'(i));
      end
    end
  endtask

  task automatic test_jumps();
    do_br(8'h10);
    do_rel(8'hF0);
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL rel_back_wrap: got %h want 00", pc); end
    do_rel(8'h05);
    tests_run++; if (pc !== 8'h05) begin tests_failed++; $display("FAIL rel_fwd: got %h want 05", pc); end
    do_br(8'hA0);
    tests_run++; if (pc !== 8'hA0) begin tests_failed++; $display("FAIL abs_jump: got %h want a0", pc); end
    do_br(8'hFE);
    do_rel(8'h03);
    tests_run++; if (pc !== 8'h01) begin tests_failed++; $display("FAIL rel_fwd_wrap: got %h want 01", pc); end
  endtask

  task automatic test_nested_call();
    do_br(8'h20);
    do_call(8'h40);
    tests_run++; if (pc !== 8'h40 || tos !== 8'h21) begin
      tests_failed++; $display("FAIL call1: got pc=%h tos=%h want pc=40 tos=21", pc, tos); end
    do_call(8'h60);
    tests_run++; if (stk_depth !== 4'd2 || tos !== 8'h41 || pc !== 8'h60) begin
      tests_failed++; $display("FAIL call2: got depth=%0d tos=%h pc=%h want 2 41 60", stk_depth, tos, pc); end
    do_rtn();
    tests_run++; if (pc !== 8'h41 || tos !== 8'h21) begin
      tests_failed++; $display("FAIL rtn1: got pc=%h tos=%h want pc=41 tos=21", pc, tos); end
    do_rtn();
    tests_run++; if (pc !== 8'h21 || stk_empty !== 1'b1 || tos !== 8'h00) begin
      tests_failed++; $display("FAIL rtn2: got pc=%h empty=%b tos=%h want 21 1 00", pc, stk_empty, tos); end
  endtask

  task automatic test_back_to_back();
    do_br(8'h7E);
    do_call(8'hC0);
    do_rtn();
    tests_run++; if (pc !== 8'h7F || stk_empty !== 1'b1) begin
      tests_failed++; $display("FAIL call_rtn: got pc=%h empty=%b want 7f 1", pc, stk_empty); end
    do_br(8'hFF);
    do_call(8'h10);
    tests_run++; if (tos !== 8'h00 || stk_depth !== 4'd1) begin
      tests_failed++; $display("FAIL push_wrap: got tos=%h depth=%0d want 00 1", tos, stk_depth); end
    do_rtn();
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL rtn_wrap: got %h want 00", pc); end
  endtask

  task automatic test_ovf_unf();
    logic [AW-1:0] held;
    do_clr();
    for (int i = 0; i < SD; i++) do_call(AW'(i * 16 + 3));
    tests_run++; if (stk_depth !== 4'd8 || stk_full !== 1'b1 || stk_ovf !== 1'b0) begin
      tests_failed++; $display("FAIL fill: got depth=%0d full=%b ovf=%b want 8 1 0", stk_depth, stk_full, stk_ovf); end
    held = pc;
    do_call(8'hEE);
    tests_run++; if (pc !== held || stk_depth !== 4'd8 || stk_ovf !== 1'b1) begin
      tests_failed++; $display("FAIL overflow: got pc=%h depth=%0d ovf=%b want %h 8 1", pc, stk_depth, stk_ovf, held); end
    for (int i = 0; i < SD; i++) begin
      do_rtn();
      tests_run++; if (pc !== m_pc || tos !== m_tos()) begin
        tests_failed++; $display("FAIL drain_%0d: got pc=%h tos=%h want %h %h", i, pc, tos, m_pc, m_tos()); end
    end
    held = pc;
    do_rtn();
    tests_run++; if (pc !== held || stk_unf !== 1'b1 || stk_depth !== 4'd0) begin
      tests_failed++; $display("FAIL underflow: got pc=%h unf=%b depth=%0d want %h 1 0", pc, stk_unf, stk_depth, held); end
    do_clr();
    tests_run++; if ({stk_ovf, stk_unf} !== 2'b00) begin
      tests_failed++; $display("FAIL clr_err: got %b want 00", {stk_ovf, stk_unf}); end
    drive(0,0,0,0,0,1,1,'0,'0);
    tests_run++; if ({stk_ovf, stk_unf} !== 2'b01) begin
      tests_failed++; $display("FAIL clr_vs_unf: got %b want 01", {stk_ovf, stk_unf}); end
    do_clr();
  endtask

  task automatic test_priority_stall();
    do_br(8'h30);
    do_call(8'h70);
    drive(0,1,1,0,1,1,0,8'h99,8'h00);
    tests_run++; if (pc !== 8'h31 || stk_depth !== 4'd0) begin
      tests_failed++; $display("FAIL priority_rtn: got pc=%h depth=%0d want 31 0", pc, stk_depth); end
    do_rtn();
    do_call(8'h44);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
            AW'($urandom), AW'($urandom));
      tests_run++;
      if (pc !== 8'h44 || stk_depth !== 4'd1 || {stk_ovf, stk_unf} !== 2'b01 || tos !== 8'h32) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got pc=%h depth=%0d flags=%b tos=%h want 44 1 01 32",
                 i, pc, stk_depth, {stk_ovf, stk_unf}, tos);
      end
    end
    do_clr();
    do_rtn();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) do_call(AW'(8'h80 + i));
    do_br(8'h55);
    tests_run++; if (pc !== 8'h55 || stk_depth !== 4'd3) begin
      tests_failed++; $display("FAIL pre_reset: got pc=%h depth=%0d want 55 3", pc, stk_depth); end
    call = 1'b1; imm_addr = 8'h12;
    #2 reset = 1'b1;
    #1;
    model_reset();
    tests_run++; if (pc !== 8'h00 || stk_depth !== 4'd0 || tos !== 8'h00 || stk_empty !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset: got pc=%h depth=%0d tos=%h empty=%b want 00 0 00 1",
                               pc, stk_depth, tos, stk_empty); end
    @(posedge clk); #1;
    tests_run++; if (pc !== 8'h00) begin tests_failed++; $display("FAIL reset_held: got %h want 00", pc); end
    #2 reset = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    call = 1'b0;
    tests_run++; if (pc !== 8'h12 || stk_depth !== 4'd1 || tos !== 8'h01) begin
      tests_failed++; $display("FAIL post_reset_call: got pc=%h depth=%0d tos=%h want 12 1 01", pc, stk_depth, tos); end
    do_rtn();
  endtask

  task automatic test_random();
    logic [5:0] sb;
    logic [AW+AW+DW+4-1:0] got, exp;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 20) sb = 6'($urandom);
      else sb = 6'(1 << $urandom_range(0, 5));
      drive($urandom_range(0, 99) < 10, sb[0], sb[1], sb[2], sb[3], sb[4] | sb[5],
            $urandom_range(0, 99) < 10, AW'($urandom), AW'($urandom));
      got = {pc, tos, stk_depth, stk_empty, stk_full, stk_ovf, stk_unf};
      exp = {m_pc, m_tos(), DW'(m_stk.size()), m_stk.size() == 0, m_stk.size() == SD, m_ovf, m_unf};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random_%0d: got pc/tos/depth/e/f/o/u=%h want %h", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_jumps();
    test_nested_call();
    test_back_to_back();
    test_ovf_unf();
    test_priority_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prgrm_cnt_stk.md
# prgrm_cnt_stk

Parametrised program counter with an integrated hardware return-address stack, for the next-generation CPU core's fetch stage. It generalises the program counter in address width and adds PC-relative branches, call/return with an internal LIFO of configurable depth, a stall input, and sticky overflow/underflow error flags. The block drives the fetch address and takes its control strobes from the writeback-cycle decoder.

## Interface
- ADDR_W, 8, width of the program address and of all address ports
- STK_DEPTH, 8, number of return-address entries (2..64)
- DEPTH_W, $clog2(STK_DEPTH+1), width of stk_depth (derived, not overridden)

- clk  in  1  CPU clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  freeze: no state change this cycle, strobes ignored
- incrmnt_pc  in  1  pc <= pc + 1
- ld_brnch_addr  in  1  absolute jump, pc <= imm_addr
- ld_rel_addr  in  1  relative jump, pc <= pc + sign-extended rel_offset
- call  in  1  push pc + 1, pc <= imm_addr
- rtn  in  1  pop, pc <= popped address
- clr_err  in  1  clear stk_ovf and stk_unf
- imm_addr  in  ADDR_W  absolute target for jump/call
- rel_offset  in  ADDR_W  two's-complement offset for relative jump
- pc  out  ADDR_W  address of the next instruction to fetch
- tos  out  ADDR_W  current top-of-stack entry; 0 when empty
- stk_depth  out  DEPTH_W  number of valid entries
- stk_empty  out  1  stk_depth == 0
- stk_full  out  1  stk_depth == STK_DEPTH
- stk_ovf  out  1  sticky: call attempted while full
- stk_unf  out  1  sticky: rtn attempted while empty

## Operation
- Reset values: pc = 0, stk_depth = 0, all stack entries = 0, stk_ovf = 0, stk_unf = 0. Derived outputs follow: tos = 0, stk_empty = 1, stk_full = 0.
- Strobes are expected one-hot. Fixed priority when several are high: stall > rtn > call > ld_brnch_addr > ld_rel_addr > incrmnt_pc. Exactly one action executes per cycle.
- No strobe high: all state holds.
- All address arithmetic is modulo 2^ADDR_W. pc + 1 wraps from all-ones to 0. Relative targets wrap in both directions.
- call when not full: entry[stk_depth] <= pc + 1, stk_depth increments, pc <= imm_addr.
- call when full: no push, pc holds, stk_depth holds, stk_ovf <= 1.
- rtn when not empty: pc <= entry[stk_depth-1], stk_depth decrements. The popped entry's content is don't-care afterwards.
- rtn when empty: pc holds, stk_unf <= 1.
- clr_err clears both flags, but a new ovf/unf event in the same cycle wins, so the flag ends set. clr_err is ignored while stall is high.
- tos = entry[stk_depth-1] when not empty, else 0. It is combinational from registered state.

## Timing
- All registered outputs (pc, stk_depth, flags) change only on the clk rising edge after the strobe is sampled, or immediately on reset assertion.
- Latency is 1 cycle from strobe to new pc. A back-to-back strobe in the next cycle operates on the updated pc and stack.
- call immediately followed by rtn returns to the original pc + 1.
- stk_empty, stk_full and tos are combinational from stk_depth and the stack entries. They are valid in the same cycle as stk_depth.
- Reset asserted mid-sequence (for example, with stack depth 3 and a call pending) forces the reset values asynchronously. The first edge after deassertion obeys the strobes.
- No combinational path exists from any input to any output.

## Test plan
- Reset and increment: assert reset, release, hold incrmnt_pc for 257 cycles (ADDR_W=8) -> pc goes 0,1,…,255,0,1. Flags stay 0 and stk_empty stays 1.
- Jumps: pc=0x10, ld_rel_addr with rel_offset=0xF0 -> pc=0x00. Then ld_rel_addr with 0x05 -> 0x05. Then ld_brnch_addr with imm_addr=0xA0 -> 0xA0.
- Nested call/return: at pc=0x20 call 0x40, at 0x40 call 0x60 -> stk_depth=2, tos=0x41. Then rtn -> pc=0x41, tos=0x21. Then rtn -> pc=0x21, stk_empty=1.
- Overflow/underflow: 8 calls to fill the stack, then a 9th call -> pc unchanged, stk_depth=8, stk_ovf=1. Pop 8 times, then rtn again -> pc unchanged, stk_unf=1. clr_err -> both flags 0. clr_err together with an empty rtn -> stk_unf stays 1.
- Priority and stall: drive rtn, call, ld_brnch_addr and incrmnt_pc together -> only the pop occurs. With stall=1 and any strobe -> pc, stk_depth and flags hold for every cycle stall is high.
- Reset mid-operation: at stk_depth=3 with pc=0x55, assert reset between clock edges -> pc=0, stk_depth=0 and tos=0 immediately, before the next clk edge.
